// File: rtl/load_stall_sb.sv
// load_stall_sb: load-use hazard detector for a classic 5-stage pipeline.
// Tracks outstanding load results in a per-register countdown scoreboard.
// Stalls the ID stage while one of its source registers is still waiting on
// a load. Also keeps a saturating count of stall cycles.
module load_stall_sb #(
  parameter int AW       = 5,   // register address width
  parameter int LOAD_LAT = 1,   // stall cycles needed directly behind a load (1..7)
  parameter int SCW      = 16   // stall-counter width
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  RDaddr_EX,
  input  logic [AW-1:0]  RSaddr_ID,
  input  logic [AW-1:0]  RTaddr_ID,
  input  logic           UseRT_ID,
  input  logic           WE_EX,
  input  logic [1:0]     DMC_EX,
  input  logic           WBmux_EX,
  input  logic           Freeze,
  input  logic           Flush_ID,
  input  logic           CntClr,
  output logic           Stall,
  output logic           PC_EN,
  output logic           IFID_EN,
  output logic [SCW-1:0] StallCnt
);

  localparam int NREG = 1 << AW;

  // The EX-stage load itself covers the first stall cycle. Each counter
  // therefore only has to cover the remaining LOAD_LAT-1 cycles.
  localparam logic [2:0] LOAD_VAL = 3'(LOAD_LAT - 1);

  // EX-stage instruction classification
  logic ld_ex;   // load whose result lands in a real register
  logic wr_ex;   // non-load write that supersedes any pending load result

  // Scoreboard storage. Register 0 has no entry, so its counter reads as zero.
  logic [2:0] cnt_q  [1:NREG-1];
  logic [2:0] cnt_rd [NREG];

  logic rs_match;
  logic rt_match;
  logic hazard;

  // Decode what the EX-stage instruction will do to the register file.
  assign ld_ex = WE_EX & WBmux_EX & (DMC_EX != 2'b00) & (RDaddr_EX != '0);
  assign wr_ex = WE_EX & (RDaddr_EX != '0) & ~ld_ex;

  // Read view of the scoreboard, with register 0 pinned to zero.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first; a
    // path that leaves one unassigned would infer a latch.
    cnt_rd[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_rd[r] = cnt_q[r];
    end
  end

  // A source conflicts if a load to it sits in EX right now, or if an older
  // load to it has not yet finished counting down.
  always_comb begin
    rs_match = (RSaddr_ID != '0) &
               ((ld_ex & (RDaddr_EX == RSaddr_ID)) | (cnt_rd[RSaddr_ID] != 3'd0));
    rt_match = (RTaddr_ID != '0) &
               ((ld_ex & (RDaddr_EX == RTaddr_ID)) | (cnt_rd[RTaddr_ID] != 3'd0));
    hazard   = rs_match | (UseRT_ID & rt_match);
  end

  // Pipeline control, in priority order: reset, freeze, flush, hazard.
  always_comb begin
    Stall   = 1'b0;
    PC_EN   = 1'b1;
    IFID_EN = 1'b1;
    if (!rst_n || Freeze) begin
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
    end else if (Flush_ID) begin
      // The ID instruction is being killed, so its dependency is moot.
      Stall   = 1'b0;
    end else if (hazard) begin
      Stall   = 1'b1;
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
    end
  end

  // Scoreboard update: a load in EX arms its counter. A plain write clears it.
  // Other counters tick down. Everything holds while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is state that must read empty right after reset, so
      // it is reset element by element. A plain data RAM would not be reset.
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else if (!Freeze) begin
      for (int r = 1; r < NREG; r++) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // entry sees pre-edge values regardless of loop order.
        if (ld_ex && (RDaddr_EX == AW'(r))) begin
          cnt_q[r] <= LOAD_VAL;
        end else if (wr_ex && (RDaddr_EX == AW'(r))) begin
          cnt_q[r] <= 3'd0;
        end else if (cnt_q[r] != 3'd0) begin
          cnt_q[r] <= cnt_q[r] - 3'd1;
        end
      end
    end
  end

  // Saturating stall-cycle counter with a synchronous clear that wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
    end else if (Stall && (StallCnt != '1)) begin
      StallCnt <= StallCnt + SCW'(1);
    end
  end

endmodule

// File: tb/tb_load_stall_sb.sv
// tb_load_stall_sb: directed tests for load_stall_sb.
// Three instances share one stimulus stream:
//   - dut_l1: LOAD_LAT=1
//   - dut_l3: LOAD_LAT=3
//   - dut_l2: LOAD_LAT=2, SCW=2
// Each test task drives its scenario and compares against hand-computed values.
module tb_load_stall_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RDaddr_EX, RSaddr_ID, RTaddr_ID;
  logic       UseRT_ID, WE_EX, WBmux_EX, Freeze, Flush_ID, CntClr;
  logic [1:0] DMC_EX;

  logic        stall_l1, pc_en_l1, ifid_en_l1;
  logic        stall_l3, pc_en_l3, ifid_en_l3;
  logic        stall_l2, pc_en_l2, ifid_en_l2;
  logic [15:0] cnt_l1, cnt_l3;
  logic [1:0]  cnt_l2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  load_stall_sb #(.AW(5), .LOAD_LAT(1), .SCW(16)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .RDaddr_EX(RDaddr_EX), .RSaddr_ID(RSaddr_ID),
    .RTaddr_ID(RTaddr_ID), .UseRT_ID(UseRT_ID), .WE_EX(WE_EX), .DMC_EX(DMC_EX),
    .WBmux_EX(WBmux_EX), .Freeze(Freeze), .Flush_ID(Flush_ID), .CntClr(CntClr),
    .Stall(stall_l1), .PC_EN(pc_en_l1), .IFID_EN(ifid_en_l1), .StallCnt(cnt_l1));

  load_stall_sb #(.AW(5), .LOAD_LAT(3), .SCW(16)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .RDaddr_EX(RDaddr_EX), .RSaddr_ID(RSaddr_ID),
    .RTaddr_ID(RTaddr_ID), .UseRT_ID(UseRT_ID), .WE_EX(WE_EX), .DMC_EX(DMC_EX),
    .WBmux_EX(WBmux_EX), .Freeze(Freeze), .Flush_ID(Flush_ID), .CntClr(CntClr),
    .Stall(stall_l3), .PC_EN(pc_en_l3), .IFID_EN(ifid_en_l3), .StallCnt(cnt_l3));

  load_stall_sb #(.AW(5), .LOAD_LAT(2), .SCW(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .RDaddr_EX(RDaddr_EX), .RSaddr_ID(RSaddr_ID),
    .RTaddr_ID(RTaddr_ID), .UseRT_ID(UseRT_ID), .WE_EX(WE_EX), .DMC_EX(DMC_EX),
    .WBmux_EX(WBmux_EX), .Freeze(Freeze), .Flush_ID(Flush_ID), .CntClr(CntClr),
    .Stall(stall_l2), .PC_EN(pc_en_l2), .IFID_EN(ifid_en_l2), .StallCnt(cnt_l2));

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    RDaddr_EX = '0; RSaddr_ID = '0; RTaddr_ID = '0; UseRT_ID = 1'b0;
    WE_EX = 1'b0; DMC_EX = 2'b00; WBmux_EX = 1'b0;
    Freeze = 1'b0; Flush_ID = 1'b0; CntClr = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    WE_EX = 1'b1; WBmux_EX = 1'b1; DMC_EX = 2'b10; RDaddr_EX = rd;
  endtask

  task automatic drive_alu(input logic [4:0] rd);
    WE_EX = 1'b1; WBmux_EX = 1'b0; DMC_EX = 2'b00; RDaddr_EX = rd;
  endtask

  task automatic drive_ex_idle();
    WE_EX = 1'b0; WBmux_EX = 1'b0; DMC_EX = 2'b00; RDaddr_EX = '0;
  endtask

  // Advance one clock; outputs are then sampled 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    drive_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  // Load to rd in EX at cycle 0. The reader (rs/rt/use_rt) enters ID k
  // slots later and stays there until no instance stalls. Independent
  // instructions fill the slots in between. Compares per-instance stall
  // cycles, StallCnt and the final PC_EN.
  task automatic run_load_case(input string name, input logic [4:0] rd, input int k,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_rt, input int e1, input int e3,
                               input int e2);
    int  n1, n3, n2;
    bit  done;
    pulse_reset();
    n1 = 0; n3 = 0; n2 = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive_idle();
      if (i == 0) drive_load(rd);
      if (i >= k) begin
        RSaddr_ID = rs; RTaddr_ID = rt; UseRT_ID = use_rt;
      end
      #1;
      if (i >= k) begin
        n1 += int'(stall_l1); n3 += int'(stall_l3); n2 += int'(stall_l2);
        if (!stall_l1 && !stall_l3 && !stall_l2) done = 1'b1;
      end
      if (!done) step();
    end
    total_cnt++;
    if (!done) $display("FAIL %s timeout: stall never cleared", name);
    else pass_cnt++;
    total_cnt++;
    if (n1 !== e1) $display("FAIL %s lat1 stalls: got %0d expected %0d", name, n1, e1);
    else pass_cnt++;
    total_cnt++;
    if (n3 !== e3) $display("FAIL %s lat3 stalls: got %0d expected %0d", name, n3, e3);
    else pass_cnt++;
    total_cnt++;
    if (n2 !== e2) $display("FAIL %s lat2 stalls: got %0d expected %0d", name, n2, e2);
    else pass_cnt++;
    total_cnt++;
    if (cnt_l1 !== 16'(e1) || cnt_l3 !== 16'(e3) || cnt_l2 !== 2'(e2))
      $display("FAIL %s StallCnt: got %0d/%0d/%0d expected %0d/%0d/%0d",
               name, cnt_l1, cnt_l3, cnt_l2, e1, e3, e2);
    else pass_cnt++;
    total_cnt++;
    if ({pc_en_l1, pc_en_l3, pc_en_l2} !== 3'b111)
      $display("FAIL %s PC_EN after stall: got %b expected 111", name,
               {pc_en_l1, pc_en_l3, pc_en_l2});
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    drive_load(5'd5); RSaddr_ID = 5'd5;   // hazard present while in reset
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if ({stall_l1, pc_en_l1, ifid_en_l1, stall_l3, pc_en_l3, ifid_en_l3,
         stall_l2, pc_en_l2, ifid_en_l2} !== 9'b0)
      $display("FAIL reset outputs: got %b expected all zero",
               {stall_l1, pc_en_l1, ifid_en_l1, stall_l3, pc_en_l3, ifid_en_l3,
                stall_l2, pc_en_l2, ifid_en_l2});
    else pass_cnt++;
    total_cnt++;
    if (cnt_l1 !== 16'd0 || cnt_l3 !== 16'd0 || cnt_l2 !== 2'd0)
      $display("FAIL reset StallCnt: got %0d/%0d/%0d expected 0/0/0", cnt_l1, cnt_l3, cnt_l2);
    else pass_cnt++;
    drive_idle();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({stall_l3, pc_en_l3, ifid_en_l3} !== 3'b011)
      $display("FAIL post-reset idle outputs: got %b expected 011",
               {stall_l3, pc_en_l3, ifid_en_l3});
    else pass_cnt++;
  endtask

  task automatic test_lat_basic();
    run_load_case("rs_k0", 5'd5, 0, 5'd5, 5'd0, 1'b0, 1, 3, 2);
  endtask

  task automatic test_use_rt();
    run_load_case("rt_used", 5'd9, 0, 5'd3, 5'd9, 1'b1, 1, 3, 2);
    run_load_case("rt_unused", 5'd9, 0, 5'd3, 5'd9, 1'b0, 0, 0, 0);
  endtask

  task automatic test_distance();
    run_load_case("k1", 5'd7, 1, 5'd7, 5'd0, 1'b0, 0, 2, 1);
    run_load_case("k2", 5'd7, 2, 5'd0, 5'd7, 1'b1, 0, 1, 0);
    run_load_case("k3", 5'd7, 3, 5'd7, 5'd0, 1'b0, 0, 0, 0);
    run_load_case("r0", 5'd0, 0, 5'd0, 5'd0, 1'b1, 0, 0, 0);
  endtask

  // Reader sits two slots behind the load, so with LOAD_LAT=3 it would
  // still see one pending cycle unless the ALU write clears the entry.
  task automatic test_alu_override();
    pulse_reset();
    drive_load(5'd4);
    step();
    drive_idle(); drive_alu(5'd4);
    step();
    drive_idle(); RSaddr_ID = 5'd4;
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b0 || pc_en_l3 !== 1'b1)
      $display("FAIL alu_clear: got stall=%b pc_en=%b expected 0/1", stall_l3, pc_en_l3);
    else pass_cnt++;
    // A write to a different register must leave r4 pending.
    pulse_reset();
    drive_load(5'd4);
    step();
    drive_idle(); drive_alu(5'd8);
    step();
    drive_idle(); RSaddr_ID = 5'd4;
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b1)
      $display("FAIL alu_other_reg: got stall=%b expected 1", stall_l3);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    pulse_reset();
    drive_load(5'd6); RSaddr_ID = 5'd6;
    #1;
    total_cnt++;
    if (stall_l2 !== 1'b1)
      $display("FAIL freeze pre: got stall=%b expected 1", stall_l2);
    else pass_cnt++;
    step();
    // Frozen, with an ALU write to r6 in EX that must not be applied.
    for (int i = 0; i < 3; i++) begin
      drive_idle(); drive_alu(5'd6); RSaddr_ID = 5'd6; Freeze = 1'b1;
      #1;
      total_cnt++;
      if ({stall_l2, pc_en_l2, ifid_en_l2} !== 3'b000 || cnt_l2 !== 2'd1)
        $display("FAIL freeze cycle %0d: got outs=%b cnt=%0d expected 000 cnt=1", i,
                 {stall_l2, pc_en_l2, ifid_en_l2}, cnt_l2);
      else pass_cnt++;
      step();
    end
    drive_idle(); RSaddr_ID = 5'd6;
    #1;
    total_cnt++;
    if (stall_l2 !== 1'b1 || stall_l3 !== 1'b1)
      $display("FAIL freeze resume: got stall l2=%b l3=%b expected 1/1", stall_l2, stall_l3);
    else pass_cnt++;
    step();
    total_cnt++;
    if (stall_l2 !== 1'b0 || pc_en_l2 !== 1'b1 || stall_l3 !== 1'b1)
      $display("FAIL freeze tail: got l2 stall=%b pc=%b l3 stall=%b expected 0/1/1",
               stall_l2, pc_en_l2, stall_l3);
    else pass_cnt++;
    step();
    total_cnt++;
    if (stall_l3 !== 1'b0 || cnt_l3 !== 16'd3 || cnt_l2 !== 2'd2)
      $display("FAIL freeze end: got l3 stall=%b cnt l3=%0d l2=%0d expected 0/3/2",
               stall_l3, cnt_l3, cnt_l2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    drive_load(5'd5); RSaddr_ID = 5'd5;
    step();
    drive_ex_idle();
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b1 || cnt_l3 !== 16'd1)
      $display("FAIL mid-stall setup: got stall=%b cnt=%0d expected 1/1", stall_l3, cnt_l3);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b0 || pc_en_l3 !== 1'b0 || cnt_l3 !== 16'd0)
      $display("FAIL async reset: got stall=%b pc=%b cnt=%0d expected 0/0/0",
               stall_l3, pc_en_l3, cnt_l3);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b0 || pc_en_l3 !== 1'b1)
      $display("FAIL reader after reset: got stall=%b pc=%b expected 0/1", stall_l3, pc_en_l3);
    else pass_cnt++;
    step();
    total_cnt++;
    if (stall_l3 !== 1'b0 || cnt_l3 !== 16'd0)
      $display("FAIL reader next cycle: got stall=%b cnt=%0d expected 0/0", stall_l3, cnt_l3);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    pulse_reset();
    drive_load(5'd5); RSaddr_ID = 5'd5; Flush_ID = 1'b1;
    #1;
    total_cnt++;
    if ({stall_l3, pc_en_l3, ifid_en_l3} !== 3'b011)
      $display("FAIL flush hazard: got %b expected 011", {stall_l3, pc_en_l3, ifid_en_l3});
    else pass_cnt++;
    Freeze = 1'b1;
    #1;
    total_cnt++;
    if ({stall_l3, pc_en_l3, ifid_en_l3} !== 3'b000)
      $display("FAIL freeze over flush: got %b expected 000", {stall_l3, pc_en_l3, ifid_en_l3});
    else pass_cnt++;
    Freeze = 1'b0; Flush_ID = 1'b0;
    #1;
    total_cnt++;
    if ({stall_l3, pc_en_l3, ifid_en_l3} !== 3'b100)
      $display("FAIL hazard no flush: got %b expected 100", {stall_l3, pc_en_l3, ifid_en_l3});
    else pass_cnt++;
    // The load was recorded on the stalling edge.
    step();
    drive_ex_idle();
    #1;
    total_cnt++;
    if (stall_l3 !== 1'b1)
      $display("FAIL write during stall: got stall=%b expected 1", stall_l3);
    else pass_cnt++;
  endtask

  task automatic test_counter_limits();
    pulse_reset();
    drive_load(5'd5); RSaddr_ID = 5'd5;
    for (int i = 0; i < 5; i++) step();
    total_cnt++;
    if (cnt_l2 !== 2'd3 || cnt_l3 !== 16'd5 || cnt_l1 !== 16'd5)
      $display("FAIL saturation: got l2=%0d l3=%0d l1=%0d expected 3/5/5", cnt_l2, cnt_l3, cnt_l1);
    else pass_cnt++;
    CntClr = 1'b1;
    step();
    total_cnt++;
    if (cnt_l2 !== 2'd0 || cnt_l3 !== 16'd0)
      $display("FAIL clear priority: got l2=%0d l3=%0d expected 0/0", cnt_l2, cnt_l3);
    else pass_cnt++;
    CntClr = 1'b0;
    step();
    total_cnt++;
    if (cnt_l3 !== 16'd1 || cnt_l2 !== 2'd1)
      $display("FAIL count after clear: got l3=%0d l2=%0d expected 1/1", cnt_l3, cnt_l2);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lat_basic();
    test_use_rt();
    test_distance();
    test_alu_override();
    test_freeze();
    test_reset_mid_stall();
    test_flush();
    test_counter_limits();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_stall_sb.md
LOAD_STALL_SB -- requirements
Module: load_stall_sb

Interface
REQ-001 Parameters SHALL be:
  - AW, default 5: register address width; NREG = 2^AW.
  - LOAD_LAT, default 1, legal range 1..7: stall cycles required by an instruction directly behind a load.
  - SCW, default 16: stall-counter width.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 RDaddr_EX  in  AW  destination register of the EX-stage instruction.
REQ-005 RSaddr_ID  in  AW  source A of the ID-stage instruction.
REQ-006 RTaddr_ID  in  AW  source B of the ID-stage instruction.
REQ-007 UseRT_ID  in  1  ID-stage instruction reads RTaddr_ID.
REQ-008 WE_EX  in  1  EX-stage register-file write enable.
REQ-009 DMC_EX  in  2  EX-stage data-memory control; nonzero means a memory access.
REQ-010 WBmux_EX  in  1  EX-stage writeback source; 1 = memory data.
REQ-011 Freeze  in  1  global pipeline hold (data memory not ready).
REQ-012 Flush_ID  in  1  ID-stage instruction is being killed this cycle.
REQ-013 CntClr  in  1  synchronous clear of StallCnt.
REQ-014 Stall  out  1  inject a bubble into ID/EX.
REQ-015 PC_EN  out  1  PC enable.
REQ-016 IFID_EN  out  1  IF/ID pipeline-register enable.
REQ-017 StallCnt  out  SCW  saturating count of cycles with Stall=1.

Function
REQ-018 The block SHALL define ld_EX = WE_EX & WBmux_EX & (DMC_EX != 0) & (RDaddr_EX != 0).
REQ-019 The block SHALL define wr_EX = WE_EX & (RDaddr_EX != 0) & ~ld_EX.
REQ-020 The block SHALL hold a scoreboard of NREG 3-bit countdown counters cnt[r]; cnt[0] SHALL be constant 0.
REQ-021 The block SHALL define match(a) = (a != 0) & ((ld_EX & RDaddr_EX == a) | (cnt[a] != 0)).
REQ-022 The block SHALL define hazard = match(RSaddr_ID) | (UseRT_ID & match(RTaddr_ID)).
REQ-023 Outputs SHALL be combinational from inputs and state, with the first applicable row taking priority:
  - rst_n=0 -> Stall=0, PC_EN=0, IFID_EN=0.
  - Freeze=1 -> Stall=0, PC_EN=0, IFID_EN=0.
  - Flush_ID=1 -> Stall=0, PC_EN=1, IFID_EN=1.
  - hazard=1 -> Stall=1, PC_EN=0, IFID_EN=0.
  - otherwise -> Stall=0, PC_EN=1, IFID_EN=1.
REQ-024 On a clock edge with Freeze=1, all cnt[] SHALL hold and no entry SHALL be written.
REQ-025 On a clock edge with Freeze=0, every nonzero cnt[r] SHALL decrement by 1.
REQ-026 On a clock edge with Freeze=0 and ld_EX=1, cnt[RDaddr_EX] SHALL load LOAD_LAT-1; this write SHALL override the decrement of that entry.
REQ-027 On a clock edge with Freeze=0 and wr_EX=1, cnt[RDaddr_EX] SHALL be cleared to 0, because the younger ALU result supersedes the pending load.
REQ-028 Consequence of REQ-018..027: a dependent instruction k slots behind a load (k=0 immediately behind) SHALL stall max(LOAD_LAT-k, 0) cycles, with no Freeze cycles in between.
REQ-029 StallCnt SHALL increment by 1 on each edge where Stall=1 and SHALL saturate at 2^SCW-1.
REQ-030 CntClr=1 SHALL zero StallCnt and SHALL take priority over an increment in the same cycle.
REQ-031 Register 0 SHALL never cause a hazard, whether as a source or as a destination.
REQ-032 A Stall in one cycle SHALL NOT suppress the scoreboard update from the EX-stage instruction in that same cycle.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately clear all cnt[] and StallCnt and force the outputs of REQ-023 row 1, regardless of clk.
REQ-034 Asserting reset mid-stall SHALL discard all pending hazards.
REQ-035 After rst_n rises, the first edge SHALL see an empty scoreboard.

Verification
REQ-036 LOAD_LAT=1: load r5 in EX, RS_ID=5 -> Stall=1 for exactly 1 cycle, then PC_EN=1; StallCnt=1.
REQ-037 LOAD_LAT=3, dependent immediately behind the load on RT with UseRT_ID=1 -> 3 stall cycles. Same case with UseRT_ID=0 -> 0 stall cycles.
REQ-038 LOAD_LAT=3, load r7, then independent instruction, then reader of r7 -> reader stalls 2 cycles. Load r0 -> 0 stall cycles.
REQ-039 LOAD_LAT=3, load r4 followed by ALU write r4, then reader of r4 -> 0 stall cycles, because cnt[4] is cleared.
REQ-040 LOAD_LAT=2, Freeze=1 for 3 cycles inserted mid-stall -> outputs Stall=0, PC_EN=0, IFID_EN=0 during Freeze; cnt holds; 1 remaining stall cycle after Freeze drops.
REQ-041 Covers reset, flush and counter limits:
  - rst_n=0 mid-stall -> Stall=0 asynchronously, StallCnt=0; the reader proceeds with no stall after reset.
  - Flush_ID=1 with hazard present -> Stall=0.
  - SCW=2 -> StallCnt saturates at 3.
